// File: rtl/pwm_dec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pwm_dec_pkg                                                  |
// | Description : Shared defaults and the state encoding for the PWM duty      |
// |               decoder.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pwm_dec_pkg;

  localparam int FRAME_BITS_DEF = 6;   // 64-cycle PWM frame
  localparam int RUN_BITS_DEF   = 8;   // envelope run counter width
  localparam int HI_THRESH_DEF  = 48;
  localparam int LO_THRESH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pwm_duty_decoder_if                                          |
// | Description : Control/stream inputs and measurement outputs of the PWM     |
// |               duty decoder.                                                |
// |   Enable, Pulse_In          : driven by the master (source side)           |
// |   Duty_Cycle, Duty_Valid    : per-frame duty measurement                   |
// |   Env_Level                 : recovered envelope                           |
// |   Env_Width, Env_Width_Valid: length of last envelope high phase (frames)  |
// |   Aligned                   : decoder is framing (MEASURE)                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pwm_duty_decoder_if #(
  parameter int FRAME_BITS = pwm_dec_pkg::FRAME_BITS_DEF,
  parameter int RUN_BITS   = pwm_dec_pkg::RUN_BITS_DEF
);
  logic                  Enable;
  logic                  Pulse_In;
  logic [FRAME_BITS:0]   Duty_Cycle;
  logic                  Duty_Valid;
  logic                  Env_Level;
  logic [RUN_BITS-1:0]   Env_Width;
  logic                  Env_Width_Valid;
  logic                  Aligned;

  modport master (
    output Enable, Pulse_In,
    input  Duty_Cycle, Duty_Valid, Env_Level, Env_Width, Env_Width_Valid, Aligned
  );

  modport slave (
    input  Enable, Pulse_In,
    output Duty_Cycle, Duty_Valid, Env_Level, Env_Width, Env_Width_Valid, Aligned
  );
endinterface
`default_nettype wire

// File: rtl/pwm_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_input_sync                                               |
// | Description : Two-flop synchronizer for the PWM input stream. Only built   |
// |               when PWM_DEC_SYNC_EN is defined.                             |
// |   clk, rst : clock and asynchronous active-high reset (flops reset to 0)   |
// |   d        : asynchronous input                                            |
// |   q        : synchronized output (2-cycle latency)                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`ifdef PWM_DEC_SYNC_EN
module pwm_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule
`endif
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_duty_decoder                                             |
// | Description : Measures the duty cycle of each 2^FRAME_BITS-cycle PWM frame |
// |               and recovers the slow envelope carried by those duties with  |
// |               hysteresis, reporting each envelope high width in frames.    |
// |   sysclk, reset : clock, asynchronous active-high reset                    |
// |   bus (slave)   : Enable/Pulse_In in; Duty_Cycle/Duty_Valid, Env_Level,    |
// |                   Env_Width/Env_Width_Valid, Aligned out                   |
// | Build option : PWM_DEC_SYNC_EN - insert a 2-flop synchronizer on Pulse_In  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int HI_THRESH  = HI_THRESH_DEF,
  parameter int LO_THRESH  = LO_THRESH_DEF,
  parameter int RUN_BITS   = RUN_BITS_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  pwm_duty_decoder_if.slave bus
);

  localparam logic [FRAME_BITS:0] HI_C = HI_THRESH[FRAME_BITS:0];
  localparam logic [FRAME_BITS:0] LO_C = LO_THRESH[FRAME_BITS:0];

  logic                  s;
  logic [FRAME_BITS:0]   s_ext;

`ifdef PWM_DEC_SYNC_EN
  pwm_input_sync u_sync (
    .clk (sysclk),
    .rst (reset),
    .d   (bus.Pulse_In),
    .q   (s)
  );
`else
  assign s = bus.Pulse_In;
`endif

  assign s_ext = {{FRAME_BITS{1'b0}}, s};

  state_t                state_d,  state_q;
  logic                  s_prev_d, s_prev_q;
  logic [FRAME_BITS-1:0] fcnt_d,   fcnt_q;
  logic [FRAME_BITS-1:0] tcnt_d,   tcnt_q;     // SEEK timeout counter
  logic [FRAME_BITS:0]   acc_d,    acc_q;
  logic [FRAME_BITS:0]   duty_d,   duty_q;
  logic                  dvalid_d, dvalid_q;
  logic                  env_d,    env_q;
  logic [RUN_BITS-1:0]   run_d,    run_q;
  logic [RUN_BITS-1:0]   width_d,  width_q;
  logic                  wvalid_d, wvalid_q;

  always_comb begin
    state_d  = state_q;
    s_prev_d = s;
    fcnt_d   = fcnt_q;
    tcnt_d   = tcnt_q;
    acc_d    = acc_q;
    duty_d   = duty_q;
    dvalid_d = 1'b0;
    env_d    = env_q;
    run_d    = run_q;
    width_d  = width_q;
    wvalid_d = 1'b0;

    if (!bus.Enable) begin
      // Disable discards the partial frame and the envelope, but keeps the
      // last reported duty and width.
      state_d = IDLE;
      fcnt_d  = '0;
      tcnt_d  = '0;
      acc_d   = '0;
      env_d   = 1'b0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEEK;
          tcnt_d  = '0;
        end
        SEEK: begin
          if (s && !s_prev_q) begin
            // The edge sample itself is frame sample 0.
            state_d = MEASURE;
            fcnt_d  = FRAME_BITS'(1);
            acc_d   = s_ext;
          end else if (&tcnt_q) begin
            // No edge (constant 0%/100% input): start framing anyway.
            state_d = MEASURE;
            fcnt_d  = '0;
            acc_d   = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        MEASURE: begin
          fcnt_d = fcnt_q + 1'b1;
          if (&fcnt_q) begin
            duty_d   = acc_q + s_ext;
            acc_d    = '0;
            dvalid_d = 1'b1;
          end else begin
            acc_d = acc_q + s_ext;
          end
        end
        default: state_d = IDLE;
      endcase

      // Envelope follows the freshly registered duty value.
      if (dvalid_q) begin
        if (!env_q && (duty_q >= HI_C)) begin
          env_d = 1'b1;
          run_d = RUN_BITS'(1);
        end else if (env_q && (duty_q <= LO_C)) begin
          env_d    = 1'b0;
          width_d  = run_q;
          wvalid_d = 1'b1;
        end else if (env_q && !(&run_q)) begin
          run_d = run_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      s_prev_q <= 1'b0;
      fcnt_q   <= '0;
      tcnt_q   <= '0;
      acc_q    <= '0;
      duty_q   <= '0;
      dvalid_q <= 1'b0;
      env_q    <= 1'b0;
      run_q    <= '0;
      width_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_prev_q <= s_prev_d;
      fcnt_q   <= fcnt_d;
      tcnt_q   <= tcnt_d;
      acc_q    <= acc_d;
      duty_q   <= duty_d;
      dvalid_q <= dvalid_d;
      env_q    <= env_d;
      run_q    <= run_d;
      width_q  <= width_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign bus.Duty_Cycle      = duty_q;
  assign bus.Duty_Valid      = dvalid_q;
  assign bus.Env_Level       = env_q;
  assign bus.Env_Width       = width_q;
  assign bus.Env_Width_Valid = wvalid_q;
  assign bus.Aligned         = (state_q == MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_duty_decoder                                          |
// | Description : Directed self-checking bench for pwm_duty_decoder (default   |
// |               build, Pulse_In sampled directly).                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_duty_decoder;

  logic sysclk = 1'b0;
  logic reset;

  pwm_duty_decoder_if #(.FRAME_BITS(6), .RUN_BITS(8)) bus ();

  pwm_duty_decoder #(
    .FRAME_BITS (6),
    .HI_THRESH  (48),
    .LO_THRESH  (16),
    .RUN_BITS   (8)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dq[$];
  int dstamp[$];
  int wq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock with Pulse_In = p; strobes are logged #1 after the edge.
  task automatic step(input logic p);
    bus.Pulse_In = p;
    @(posedge sysclk);
    #1;
    cyc++;
    if (bus.Duty_Valid === 1'b1) begin
      dq.push_back(int'(bus.Duty_Cycle));
      dstamp.push_back(cyc);
    end
    if (bus.Env_Width_Valid === 1'b1) wq.push_back(int'(bus.Env_Width));
  endtask

  task automatic clear_logs();
    dq.delete();
    dstamp.delete();
    wq.delete();
  endtask

  task automatic restart();
    bus.Enable = 1'b0;
    step(1'b0);
    clear_logs();
    bus.Enable = 1'b1;
    repeat (5) step(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hyst[4];
    hyst = '{48, 30, 17, 16};

    reset        = 1'b1;
    bus.Enable   = 1'b0;
    bus.Pulse_In = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check_eq("rst_duty",   bus.Duty_Cycle,      0);
    check_eq("rst_dvalid", bus.Duty_Valid,      0);
    check_eq("rst_env",    bus.Env_Level,       0);
    check_eq("rst_width",  bus.Env_Width,       0);
    check_eq("rst_wvalid", bus.Env_Width_Valid, 0);
    check_eq("rst_align",  bus.Aligned,         0);
    reset = 1'b0;

    // Constant high: SEEK times out, every frame reads 64.
    clear_logs();
    bus.Enable = 1'b1;
    repeat (64) step(1'b1);
    check_eq("t1_not_aligned_yet", bus.Aligned, 0);
    step(1'b1);
    check_eq("t1_timeout_aligned", bus.Aligned, 1);
    repeat (192) step(1'b1);
    check_eq("t1_frame_count", dq.size(), 3);
    foreach (dq[k]) check_eq("t1_duty", dq[k], 64);
    check_eq("t1_period", dstamp[1] - dstamp[0], 64);
    check_eq("t1_env_high", bus.Env_Level, 1);

    // Drop Enable at fcnt=20.
    repeat (20) step(1'b1);
    bus.Enable = 1'b0;
    step(1'b1);
    check_eq("dis_no_dvalid", dq.size(), 3);
    check_eq("dis_no_wvalid", wq.size(), 0);
    check_eq("dis_env_clr",   bus.Env_Level, 0);
    check_eq("dis_unaligned", bus.Aligned, 0);
    check_eq("dis_duty_hold", bus.Duty_Cycle, 64);

    // 16/64 PWM aligned on its first rising edge.
    clear_logs();
    bus.Enable = 1'b1;
    repeat (5) step(1'b0);
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 64; j++) begin
        step(j < 16);
        if (f == 0 && j == 62) check_eq("t2_duty_hold_old", bus.Duty_Cycle, 64);
      end
    end
    check_eq("t2_frame_count", dq.size(), 4);
    foreach (dq[k]) check_eq("t2_duty", dq[k], 16);
    check_eq("t2_env_low", bus.Env_Level, 0);

    // Enable low in the frame-end cycle: no strobe.
    for (int j = 0; j < 63; j++) step(j < 16);
    bus.Enable = 1'b0;
    step(1'b0);
    check_eq("t2_end_vs_disable", dq.size(), 4);

    // Generator pattern: 32 frames 100%, 32 frames 0%, repeating.
    restart();
    for (int i = 0; i < 6400; i++) begin
      step(((i / 2048) % 2) == 0);
      if (i == 2560) check_eq("t3_env_low_phase",  bus.Env_Level, 0);
      if (i == 4480) check_eq("t3_env_high_phase", bus.Env_Level, 1);
    end
    check_eq("t3_width_count", wq.size(), 2);
    foreach (wq[k]) check_eq("t3_width", wq[k], 32);

    // Hysteresis: 48, 30, 17, 16.
    restart();
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 64; j++) begin
        step(j < hyst[f]);
        if (f == 1 && j == 0) check_eq("t4_env_rise", bus.Env_Level, 1);
      end
    end
    repeat (2) step(1'b0);
    check_eq("t4_frame_count", dq.size(), 4);
    foreach (dq[k]) check_eq("t4_duty", dq[k], hyst[k]);
    check_eq("t4_width_count", wq.size(), 1);
    if (wq.size() > 0) check_eq("t4_width", wq[0], 3);
    check_eq("t4_env_fall", bus.Env_Level, 0);

    // Run counter saturation: 258 full frames then one empty frame.
    restart();
    for (int i = 0; i < 258 * 64; i++) step(1'b1);
    check_eq("t6_env_high", bus.Env_Level, 1);
    for (int j = 0; j < 66; j++) step(1'b0);
    check_eq("t6_width_count", wq.size(), 1);
    if (wq.size() > 0) check_eq("t6_width_sat", wq[0], 255);

    // Asynchronous reset mid-MEASURE.
    repeat (10) step(1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("ar_duty",  bus.Duty_Cycle, 0);
    check_eq("ar_width", bus.Env_Width,  0);
    check_eq("ar_align", bus.Aligned,    0);
    check_eq("ar_env",   bus.Env_Level,  0);
    check_eq("ar_dvalid", bus.Duty_Valid, 0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    step(1'b1);
    check_eq("ar_restart_seek", bus.Aligned, 0);
    repeat (64) step(1'b1);
    check_eq("ar_restart_aligned", bus.Aligned, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
